// File: rtl/data_bus_arbiter_if.sv
// Master-facing bundle of the data SRAM arbiter: two req/ack ports, shared read data,
// and the SRAM control/address lines. The tri-state data bus stays a plain inout port.
interface data_bus_arbiter_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 7
);
    logic                    m0_req;
    logic                    m0_we;
    logic [D_ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0]   m0_wdata;
    logic                    m0_ack;
    logic                    m1_req;
    logic                    m1_we;
    logic [D_ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0]   m1_wdata;
    logic                    m1_ack;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    sram_cs;
    logic                    sram_we;
    logic                    sram_oe;
    logic [D_ADDR_WIDTH-1:0] sram_addr;
    logic                    busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m1_ack, rdata,
        output sram_cs, sram_we, sram_oe, sram_addr, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m1_ack, rdata,
        input  sram_cs, sram_we, sram_oe, sram_addr, busy
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Shares the single-ported data SRAM between CPU (port 0) and a secondary master; round-robin, or CPU-first with CPU_PRIORITY_EN.
// Latency: ack 2 cycles after req is sampled in IDLE; one transaction per 3 cycles.
// Backpressure: masters hold req and fields until ack; a losing port simply waits for the next IDLE.
module data_bus_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 7
) (
    input  logic                  osc_clk,
    input  logic                  corrected_reset,
    data_bus_arbiter_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [D_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]   wdata;
    } txn_t;

    state_t state, state_nxt;
    logic   owner;
    logic   last_grant;
    logic   any_req;
    logic   winner;
    txn_t   txn, txn_nxt;

    // Grant decision; only consumed while IDLE.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
`ifdef CPU_PRIORITY_EN
        winner = ~bus.m0_req;
`else
        if (bus.m0_req && bus.m1_req) begin
            winner = ~last_grant;
        end else begin
            winner = ~bus.m0_req;
        end
`endif
        if (winner) begin
            txn_nxt.we    = bus.m1_we;
            txn_nxt.addr  = bus.m1_addr;
            txn_nxt.wdata = bus.m1_wdata;
        end else begin
            txn_nxt.we    = bus.m0_we;
            txn_nxt.addr  = bus.m0_addr;
            txn_nxt.wdata = bus.m0_wdata;
        end
    end

    always_ff @(posedge osc_clk or posedge corrected_reset) begin
        if (corrected_reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            txn        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner      <= winner;
                last_grant <= winner;
                txn        <= txn_nxt;
            end
        end
    end

    // All outputs decode from state and latched fields only, never from req.
    always_comb begin
        state_nxt     = state;
        bus.m0_ack    = 1'b0;
        bus.m1_ack    = 1'b0;
        bus.sram_cs   = 1'b0;
        bus.sram_we   = 1'b0;
        bus.sram_oe   = 1'b0;
        bus.rdata     = '0;
        bus.sram_addr = txn.addr;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt   = DONE;
                bus.sram_cs = 1'b1;
                bus.sram_we = txn.we;
                bus.sram_oe = ~txn.we;
            end
            DONE: begin
                state_nxt  = IDLE;
                bus.m0_ack = ~owner;
                bus.m1_ack = owner;
                // Reads keep the SRAM selected so it is still driving the bus while ack is up.
                if (!txn.we) begin
                    bus.sram_cs = 1'b1;
                    bus.sram_oe = 1'b1;
                    bus.rdata   = sram_data;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sram_data = (state == ACCESS && txn.we) ? txn.wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed vector table, hand-written corner sequences,
// then random two-master traffic against a transaction-level reference model.
module tb_data_bus_arbiter;
    localparam int DW = 8;
    localparam int AW = 7;

    logic          osc_clk = 1'b0;
    logic          corrected_reset;
    logic          mem_init;
    wire  [DW-1:0] sram_data;

    data_bus_arbiter_if #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW)) bus ();

    data_bus_arbiter #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW)) dut (
        .osc_clk         (osc_clk),
        .corrected_reset (corrected_reset),
        .bus             (bus),
        .sram_data       (sram_data)
    );

    always #5 osc_clk = ~osc_clk;

    // SRAM device model
    logic [DW-1:0] mem     [128];
    logic [DW-1:0] ref_mem [128];

    assign sram_data = (bus.sram_cs && bus.sram_oe && !bus.sram_we) ? mem[bus.sram_addr] : {DW{1'bz}};

    always @(posedge osc_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= DW'(i * 3 + 7);
        end else if (bus.sram_cs && bus.sram_we) begin
            mem[bus.sram_addr] <= sram_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic set_m(input int p, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt[8];

    task automatic do_txn(input vec_t v);
        int o = 1 - v.port;
        set_m(v.port, 1'b1, v.we, v.addr, v.wdata);
        tick();
        check("acc_cs", bus.sram_cs, 1);
        check("acc_we", bus.sram_we, v.we);
        check("acc_oe", bus.sram_oe, !v.we);
        check("acc_addr", bus.sram_addr, v.addr);
        if (v.we) check("acc_wdata", sram_data, v.wdata);
        check("acc_no_ack", ack_of(v.port), 0);
        tick();
        check("ack", ack_of(v.port), 1);
        check("other_ack", ack_of(o), 0);
        check("rdata", bus.rdata, v.exp_rdata);
        check("busy_done", bus.busy, 1);
        if (!v.we) check("done_oe", bus.sram_oe, 1);
        set_m(v.port, 1'b0, 1'b0, '0, '0);
        if (v.we) ref_mem[v.addr] = v.wdata;
        tick();
        check("ack_clear", ack_of(v.port), 0);
        check("idle_busy", bus.busy, 0);
    endtask

    task automatic wait_first_ack(input int budget, output int port, output int cyc);
        port = -1;
        cyc  = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (bus.m0_ack || bus.m1_ack) begin
                port = bus.m0_ack ? 0 : 1;
                cyc  = c;
                break;
            end
        end
    endtask

    // Both masters keep requesting; four acks expected 3 cycles apart.
    task automatic contention();
        int ports[$];
        int cycs[$];
        set_m(0, 1'b1, 1'b0, 7'h20, '0);
        set_m(1, 1'b1, 1'b0, 7'h21, '0);
        for (int c = 1; c <= 20 && ports.size() < 4; c++) begin
            tick();
            check("cont_busy", bus.busy, (c % 3) != 0);
            if (bus.m0_ack || bus.m1_ack) begin
                ports.push_back(bus.m0_ack ? 0 : 1);
                cycs.push_back(c);
                check("cont_rdata", bus.rdata, ref_mem[bus.m0_ack ? 7'h20 : 7'h21]);
            end
            if (ports.size() == 4) begin
                set_m(0, 1'b0, 1'b0, '0, '0);
                set_m(1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("cont_count", ports.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ports.size()) begin
`ifdef CPU_PRIORITY_EN
                check("cont_order", ports[i], 0);
`else
                check("cont_order", ports[i], i % 2);
`endif
                check("cont_ack_cycle", cycs[i], 2 + 3 * i);
            end
        end
        tick();
        check("cont_tail_busy", bus.busy, 0);
    endtask

    task automatic random_phase(input int ncyc);
        logic          pend [2];
        int            gap  [2];
        logic          fwe  [2];
        logic [AW-1:0] fadr [2];
        logic [DW-1:0] fwd  [2];
        int            free_at, gcyc, gport, model_last, w;
        logic          gwe;
        logic [AW-1:0] gaddr;
        logic [DW-1:0] gwdata;

        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; gap[p] = p; fwe[p] = 1'b0; fadr[p] = '0; fwd[p] = '0;
            set_m(p, 1'b0, 1'b0, '0, '0);
        end
        corrected_reset = 1'b1;
        #2;
        corrected_reset = 1'b0;
        free_at = 0; gcyc = -100; gport = 0; model_last = 1; w = 0;
        gwe = 1'b0; gaddr = '0; gwdata = '0;

        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge osc_clk);
            if (cyc >= free_at && (pend[0] || pend[1])) begin
`ifdef CPU_PRIORITY_EN
                w = pend[0] ? 0 : 1;
`else
                if (pend[0] && pend[1]) w = 1 - model_last;
                else                    w = pend[0] ? 0 : 1;
`endif
                model_last = w;
                gport  = w;
                gcyc   = cyc;
                free_at = cyc + 3;
                gwe    = fwe[w];
                gaddr  = fadr[w];
                gwdata = fwd[w];
            end
            #1;
            check("rnd_busy", bus.busy, (cyc == gcyc) || (cyc == gcyc + 1));
            if (cyc == gcyc) begin
                check("rnd_cs", bus.sram_cs, 1);
                check("rnd_we", bus.sram_we, gwe);
                check("rnd_addr", bus.sram_addr, gaddr);
            end
            check("rnd_m0_ack", bus.m0_ack, (cyc == gcyc + 1) && gport == 0);
            check("rnd_m1_ack", bus.m1_ack, (cyc == gcyc + 1) && gport == 1);
            if (cyc == gcyc + 1) begin
                if (gwe) begin
                    ref_mem[gaddr] = gwdata;
                    check("rnd_rdata_wr", bus.rdata, 0);
                end else begin
                    check("rnd_rdata_rd", bus.rdata, ref_mem[gaddr]);
                end
                pend[gport] = 1'b0;
                gap[gport]  = $urandom_range(0, 4);
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if (gap[p] == 0) begin
                        pend[p] = 1'b1;
                        fwe[p]  = 1'($urandom_range(0, 1));
                        fadr[p] = AW'($urandom);
                        fwd[p]  = DW'($urandom);
                    end else begin
                        gap[p]--;
                    end
                end
                set_m(p, pend[p], fwe[p], fadr[p], fwd[p]);
            end
        end
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, c, n0, n1;
        vt[0] = '{0, 1'b1, 7'h05, 8'hA5, 8'h00};
        vt[1] = '{1, 1'b0, 7'h05, 8'h00, 8'hA5};
        vt[2] = '{1, 1'b1, 7'h10, 8'h3C, 8'h00};
        vt[3] = '{0, 1'b0, 7'h10, 8'h00, 8'h3C};
        vt[4] = '{0, 1'b1, 7'h7F, 8'h81, 8'h00};
        vt[5] = '{1, 1'b0, 7'h7F, 8'h00, 8'h81};
        vt[6] = '{0, 1'b1, 7'h00, 8'hFF, 8'h00};
        vt[7] = '{1, 1'b0, 7'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 128; i++) ref_mem[i] = DW'(i * 3 + 7);

        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        mem_init        = 1'b1;
        corrected_reset = 1'b1;
        repeat (3) tick();
        check("rst_m0_ack", bus.m0_ack, 0);
        check("rst_m1_ack", bus.m1_ack, 0);
        check("rst_cs", bus.sram_cs, 0);
        check("rst_we", bus.sram_we, 0);
        check("rst_oe", bus.sram_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_rdata", bus.rdata, 0);
        mem_init        = 1'b0;
        corrected_reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_txn(vt[i]);

        contention();

        // Back-to-back on port 1: 0x10 then 0x11
        n1 = 0;
        set_m(1, 1'b1, 1'b0, 7'h10, '0);
        for (int k = 1; k <= 12 && n1 < 2; k++) begin
            tick();
            if (bus.m1_ack) begin
                check("b2b_cycle", k, 2 + 3 * n1);
                check("b2b_addr", bus.sram_addr, 7'h10 + 7'(n1));
                check("b2b_rdata", bus.rdata, ref_mem[7'h10 + 7'(n1)]);
                n1++;
                if (n1 == 1) set_m(1, 1'b1, 1'b0, 7'h11, '0);
                else         set_m(1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("b2b_count", n1, 2);
        tick();

        // Reset in the middle of an m1 read
        set_m(1, 1'b1, 1'b0, 7'h05, '0);
        tick();
        check("rstacc_pre_cs", bus.sram_cs, 1);
        corrected_reset = 1'b1;
        #1;
        check("rstacc_cs", bus.sram_cs, 0);
        check("rstacc_oe", bus.sram_oe, 0);
        check("rstacc_we", bus.sram_we, 0);
        check("rstacc_busy", bus.busy, 0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        #2;
        corrected_reset = 1'b0;
        n1 = 0;
        repeat (4) begin
            tick();
            if (bus.m1_ack) n1++;
        end
        check("rstacc_no_ack", n1, 0);
        set_m(0, 1'b1, 1'b0, 7'h30, '0);
        set_m(1, 1'b1, 1'b0, 7'h31, '0);
        wait_first_ack(8, p, c);
        check("rstacc_first_port", p, 0);
        check("rstacc_first_cycle", c, 2);
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();

        // m0 pulses req for one cycle while m1 is being served
        set_m(1, 1'b1, 1'b1, 7'h40, 8'h77);
        tick();
        set_m(0, 1'b1, 1'b0, 7'h41, '0);
        tick();
        check("drop_m1_ack", bus.m1_ack, 1);
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        ref_mem[7'h40] = 8'h77;
        n0 = 0;
        n1 = 0;
        repeat (6) begin
            tick();
            if (bus.m0_ack) n0++;
            if (bus.busy)   n1++;
        end
        check("drop_no_m0_ack", n0, 0);
        check("drop_no_busy", n1, 0);

        random_phase(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
